// File: rtl/md_sched_if.sv
// Multiply/divide scheduler bus: E-stage request fields toward the MD unit,
// busy/done status and the architectural HI/LO registers back from it.
//   master : E-stage decode / hazard side (drives the request fields)
//   slave  : md_sched_unit (drives busy, md_done, hi, lo)
interface md_sched_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush_req;
    logic        busy;
    logic        md_done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, rs_data, rt_data, flush_req,
        input  busy, md_done, hi, lo
    );

    modport slave (
        input  start, md_op, rs_data, rt_data, flush_req,
        output busy, md_done, hi, lo
    );
endinterface

// File: rtl/md_sched_unit.sv
// Multiply/divide scheduler and HI/LO owner for the E stage.
// Accepts one mult/multu/div/divu/mthi/mtlo per start, holds busy for the
// op latency, then commits the result to HI/LO in a single edge.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low; clears HI/LO and discards any in-flight op
//   bus   : md_sched_if.slave (start, md_op, rs_data, rt_data, flush_req in;
//           busy, md_done, hi, lo out, all registered)
module md_sched_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    md_sched_if.slave   bus
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int unsigned DW         = 32;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DW-1:0]       hi_q, hi_d;
    logic [DW-1:0]       lo_q, lo_d;
    logic [DW-1:0]       a_q, a_d;
    logic [DW-1:0]       b_q, b_d;
    logic [2:0]          op_q, op_d;

    // Datapath on the latched operands; only sampled on the commit edge.
    logic                signed_op_c;
    logic                is_div_c;
    logic                div_zero_c;
    logic [2*DW-1:0]     ext_a_c, ext_b_c, prod_c;
    logic [DW-1:0]       mag_a_c, mag_b_c, q_mag_c, r_mag_c, quot_c, rem_c;

    always_comb begin
        signed_op_c = (op_q == OP_MULT) || (op_q == OP_DIV);
        is_div_c    = (op_q == OP_DIV) || (op_q == OP_DIVU);
        div_zero_c  = (b_q == '0);

        // Sign/zero-extend to 64 bits; the low 64 bits of the product are
        // correct two's-complement for both signed and unsigned forms.
        ext_a_c = signed_op_c ? {{DW{a_q[DW-1]}}, a_q} : {{DW{1'b0}}, a_q};
        ext_b_c = signed_op_c ? {{DW{b_q[DW-1]}}, b_q} : {{DW{1'b0}}, b_q};
        prod_c  = ext_a_c * ext_b_c;

        // Signed divide via magnitudes: quotient truncates toward zero and the
        // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
        // magnitude 0x80000000 re-negated to itself, remainder 0.
        mag_a_c = (signed_op_c && a_q[DW-1]) ? (DW'(0) - a_q) : a_q;
        mag_b_c = (signed_op_c && b_q[DW-1]) ? (DW'(0) - b_q) : b_q;
        q_mag_c = div_zero_c ? '0 : (mag_a_c / mag_b_c);
        r_mag_c = div_zero_c ? '0 : (mag_a_c % mag_b_c);
        quot_c  = (signed_op_c && (a_q[DW-1] ^ b_q[DW-1])) ? (DW'(0) - q_mag_c) : q_mag_c;
        rem_c   = (signed_op_c && a_q[DW-1]) ? (DW'(0) - r_mag_c) : r_mag_c;
    end

    // Next-state / output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush_req) begin
                    case (bus.md_op)
                        OP_MTHI: hi_d = bus.rs_data;
                        OP_MTLO: lo_d = bus.rs_data;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            a_d     = bus.rs_data;
                            b_d     = bus.rt_data;
                            op_d    = bus.md_op;
                            cnt_d   = ((bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU))
                                      ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Starts and flushes are ignored here: the in-flight op is
                // older than anything the hazard unit lets through.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (is_div_c) begin
                        if (!div_zero_c) begin
                            hi_d = rem_c;
                            lo_d = quot_c;
                        end
                    end else begin
                        hi_d = prod_c[2*DW-1:DW];
                        lo_d = prod_c[DW-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.md_done = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;

endmodule

// File: tb/tb_md_sched_unit.sv
module tb_md_sched_unit;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    md_sched_if bus_if ();

    md_sched_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {hi,lo} after committing op, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] h,
                                               input logic [31:0] l);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        p  = {h, l};
        case (op)
            3'd1: p = 64'(sa * sb);
            3'd2: p = 64'(ua * ub);
            3'd3: if (b != 0) begin
                sq = sa / sb;
                sr = sa % sb;
                p  = {sr[31:0], sq[31:0]};
            end
            3'd4: if (b != 0) begin
                uq = ua / ub;
                ur = ua % ub;
                p  = {ur[31:0], uq[31:0]};
            end
            default: ;
        endcase
        return p;
    endfunction

    task automatic check_state(input string tag, input logic busy_e, input logic done_e);
        chk($sformatf("%s.busy", tag), 32'(bus_if.busy), 32'(busy_e));
        chk($sformatf("%s.done", tag), 32'(bus_if.md_done), 32'(done_e));
        chk($sformatf("%s.hi", tag), bus_if.hi, hi_m);
        chk($sformatf("%s.lo", tag), bus_if.lo, lo_m);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Issue one start, then follow the op to completion. inj >= 0 drives a
    // stray start on that busy cycle, which must not disturb anything.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl, input int inj, input string tag);
        logic        acc;
        int unsigned n;
        logic [63:0] res;
        bus_if.start     = 1'b1;
        bus_if.md_op     = op;
        bus_if.rs_data   = a;
        bus_if.rt_data   = b;
        bus_if.flush_req = fl;
        step();
        bus_if.start     = 1'b0;
        bus_if.md_op     = 3'($urandom);
        bus_if.rs_data   = $urandom;
        bus_if.rt_data   = $urandom;
        bus_if.flush_req = 1'($urandom);
        acc = !fl && (op >= 3'd1) && (op <= 3'd6);
        if (acc && op == 3'd5) hi_m = a;
        if (acc && op == 3'd6) lo_m = a;
        if (acc && op <= 3'd4) begin
            n   = (op <= 3'd2) ? MC : DC;
            res = ref_result(op, a, b, hi_m, lo_m);
            for (int i = 0; i < int'(n); i++) begin
                check_state($sformatf("%s.run%0d", tag, i), 1'b1, 1'b0);
                if (i == inj) begin
                    bus_if.start     = 1'b1;
                    bus_if.md_op     = 3'($urandom_range(1, 6));
                    bus_if.flush_req = 1'($urandom);
                end
                step();
                bus_if.start = 1'b0;
            end
            {hi_m, lo_m} = res;
            check_state($sformatf("%s.commit", tag), 1'b0, 1'b1);
        end else begin
            check_state($sformatf("%s.noop", tag), 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;

        reset            = 1'b0;
        bus_if.start     = 1'b0;
        bus_if.md_op     = '0;
        bus_if.rs_data   = '0;
        bus_if.rt_data   = '0;
        bus_if.flush_req = 1'b0;
        #12;
        check_state("reset", 1'b0, 1'b0);
        step();
        reset = 1'b1;
        step();
        check_state("post_reset", 1'b0, 1'b0);

        do_op(3'd5, 32'h1234, 32'h0, 1'b0, -1, "mthi");
        do_op(3'd6, 32'h5678, 32'h0, 1'b0, -1, "mtlo");
        do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, -1, "mult");
        chk("mult.hi_abs", bus_if.hi, 32'hFFFF_FFFF);
        chk("mult.lo_abs", bus_if.lo, 32'hFFFF_FFFA);
        do_op(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, -1, "multu");
        chk("multu.hi_abs", bus_if.hi, 32'h0000_0002);
        chk("multu.lo_abs", bus_if.lo, 32'hFFFF_FFFA);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, -1, "div");
        chk("div.hi_abs", bus_if.hi, 32'hFFFF_FFFF);
        chk("div.lo_abs", bus_if.lo, 32'hFFFF_FFFD);
        do_op(3'd4, 32'd7, 32'd0, 1'b0, -1, "divu0");
        chk("divu0.hi_abs", bus_if.hi, 32'hFFFF_FFFF);
        do_op(3'd1, 32'd9, 32'd9, 1'b1, -1, "flush_mult");
        do_op(3'd0, 32'd9, 32'd9, 1'b0, -1, "op_none");
        do_op(3'd7, 32'd9, 32'd9, 1'b0, -1, "op_rsvd");
        do_op(3'd1, 32'd100, 32'hFFFF_FFFF, 1'b0, 2, "mult_inj");
        // Back-to-back: next start issued on the first busy==0 cycle.
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, "div_ovf");
        chk("div_ovf.hi_abs", bus_if.hi, 32'h0);
        chk("div_ovf.lo_abs", bus_if.lo, 32'h8000_0000);

        // Reset in the middle of a mult: outputs clear at once, nothing commits.
        do_op(3'd5, 32'hAAAA_0001, 32'h0, 1'b0, -1, "pre_rst_hi");
        do_op(3'd6, 32'h5555_0002, 32'h0, 1'b0, -1, "pre_rst_lo");
        bus_if.start   = 1'b1;
        bus_if.md_op   = 3'd1;
        bus_if.rs_data = 32'd3;
        bus_if.rt_data = 32'd4;
        step();
        bus_if.start = 1'b0;
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        hi_m = '0;
        lo_m = '0;
        check_state("rst_mid", 1'b0, 1'b0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < int'(MC) + 2; i++) begin
            step();
            check_state($sformatf("rst_after%0d", i), 1'b0, 1'b0);
        end

        // Randomized ops against the reference model.
        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            do_op(op, a, b, ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1,
                  $sformatf("rnd%0d", k));
        end

        step();
        check_state("final", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
